// File: rtl/stopwatch_counter.sv
// stopwatch_counter: BCD MM:SS.CC stopwatch stepped by rising edges of a synchronised 100 Hz wave.
// Start/stop, lap freeze and clear control; display shows the lap copy while frozen.
module stopwatch_counter #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_LIMIT   = 59
) (
    input  logic       clk_in,
    input  logic       res,
    input  logic       ena,
    input  logic       tick_in,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    output logic [2:0] min_t,
    output logic [3:0] min_u,
    output logic [2:0] sec_t,
    output logic [3:0] sec_u,
    output logic [3:0] cs_t,
    output logic [3:0] cs_u,
    output logic       running,
    output logic       lap_hold,
    output logic       wrap
);
    localparam logic [2:0] MT_MAX = 3'(MIN_LIMIT / 10);
    localparam logic [3:0] MU_MAX = 4'(MIN_LIMIT % 10);

    typedef enum logic {STOPPED, RUNNING} state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_fill;
    logic                   r_edge;
    logic                   r_step;
    logic [21:0]            r_live;
    logic [21:0]            r_lap;
    logic                   r_hold;
    logic                   r_wrap;
    logic                   w_step;
    logic                   w_cnt;
    logic [22:0]            w_inc;

    // Returns {wrap, next} for one BCD centisecond increment.
    function automatic logic [22:0] f_inc(input logic [21:0] t);
        logic [2:0] mt, st;
        logic [3:0] mu, su, ct, cu;
        logic       w;
        {mt, mu, st, su, ct, cu} = t;
        w = 1'b0;
        if (cu != 4'd9) cu = cu + 4'd1;
        else begin
            cu = '0;
            if (ct != 4'd9) ct = ct + 4'd1;
            else begin
                ct = '0;
                if (su != 4'd9) su = su + 4'd1;
                else begin
                    su = '0;
                    if (st != 3'd5) st = st + 3'd1;
                    else begin
                        st = '0;
                        if (mt == MT_MAX && mu == MU_MAX) begin
                            mt = '0;
                            mu = '0;
                            w  = 1'b1;
                        end else if (mu != 4'd9) mu = mu + 4'd1;
                        else begin
                            mu = '0;
                            mt = mt + 3'd1;
                        end
                    end
                end
            end
        end
        return {w, mt, mu, st, su, ct, cu};
    endfunction

    // The edge flop reads as high until the chain holds real samples, so a wave
    // already high at reset release is not mistaken for a rising edge.
    assign w_step = r_sync[SYNC_STAGES-1] & ~r_edge;
    assign w_cnt  = r_step & (r_state == RUNNING);
    assign w_inc  = f_inc(r_live);

    always_ff @(posedge clk_in) begin
        if (res) begin
            r_state <= STOPPED;
            r_sync  <= '0;
            r_fill  <= '0;
            r_edge  <= 1'b1;
            r_step  <= 1'b0;
            r_live  <= '0;
            r_lap   <= '0;
            r_hold  <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (ena) begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], tick_in};
            r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            r_edge <= r_fill[SYNC_STAGES-1] ? r_sync[SYNC_STAGES-1] : 1'b1;
            r_step <= w_step;
            if (clear) begin
                r_state <= STOPPED;
                r_live  <= '0;
                r_lap   <= '0;
                r_hold  <= 1'b0;
                r_wrap  <= 1'b0;
            end else begin
                r_state <= start_stop ? (r_state == RUNNING ? STOPPED : RUNNING) : r_state;
                r_wrap  <= w_cnt & w_inc[22];
                if (w_cnt) r_live <= w_inc[21:0];
                if (lap && r_hold) r_hold <= 1'b0;
                else if (lap && r_state == RUNNING) begin
                    r_lap  <= r_live;
                    r_hold <= 1'b1;
                end
            end
        end
    end

    assign {min_t, min_u, sec_t, sec_u, cs_t, cs_u} = r_hold ? r_lap : r_live;
    assign running  = (r_state == RUNNING);
    assign lap_hold = r_hold;
    assign wrap     = r_wrap;
endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter: checks a default stopwatch and a short-wrap (MIN_LIMIT=1) copy
// against a centisecond-integer model, plus hand-computed display values.
module tb_stopwatch_counter;
    logic clk_in = 1'b0, res = 1'b1, ena = 1'b1, tick_in = 1'b0, ss = 1'b0, lap_p = 1'b0, clr = 1'b0;
    logic [2:0] min_t0, sec_t0, min_tw, sec_tw;
    logic [3:0] min_u0, sec_u0, cs_t0, cs_u0, min_uw, sec_uw, cs_tw, cs_uw;
    logic running0, lap_hold0, wrap0, runningw, lap_holdw, wrapw;
    logic [21:0] d0, dw;
    int n_cmp = 0, n_bad = 0;

    int tot [2] = '{360000, 12000};
    int m_cnt [2], m_lap [2];
    bit m_run [2], m_hold [2], m_wrap [2];
    bit [4:0] hist;
    int nsamp = 0;
    bit started = 0;

    always #5 clk_in = ~clk_in;

    stopwatch_counter dut (
        .clk_in(clk_in), .res(res), .ena(ena), .tick_in(tick_in), .start_stop(ss), .lap(lap_p), .clear(clr),
        .min_t(min_t0), .min_u(min_u0), .sec_t(sec_t0), .sec_u(sec_u0), .cs_t(cs_t0), .cs_u(cs_u0),
        .running(running0), .lap_hold(lap_hold0), .wrap(wrap0));

    stopwatch_counter #(.MIN_LIMIT(1)) dut_w (
        .clk_in(clk_in), .res(res), .ena(ena), .tick_in(tick_in), .start_stop(ss), .lap(lap_p), .clear(clr),
        .min_t(min_tw), .min_u(min_uw), .sec_t(sec_tw), .sec_u(sec_uw), .cs_t(cs_tw), .cs_u(cs_uw),
        .running(runningw), .lap_hold(lap_holdw), .wrap(wrapw));

    assign d0 = {min_t0, min_u0, sec_t0, sec_u0, cs_t0, cs_u0};
    assign dw = {min_tw, min_uw, sec_tw, sec_uw, cs_tw, cs_uw};

    function automatic logic [21:0] mk(input int mm, input int s, input int c);
        return {3'(mm / 10), 4'(mm % 10), 3'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    function automatic logic [24:0] ev(input int i);
        int d;
        d = m_hold[i] ? m_lap[i] : m_cnt[i];
        return {mk(d / 6000, (d / 100) % 60, d % 100), m_run[i], m_hold[i], m_wrap[i]};
    endfunction

    // Model: a step is a 0->1 in enabled-edge samples taken three edges earlier.
    initial forever begin
        @(posedge clk_in);
        if (res) begin
            started = 1;
            hist = '0;
            nsamp = 0;
            for (int i = 0; i < 2; i++) begin
                m_cnt[i] = 0; m_lap[i] = 0; m_run[i] = 0; m_hold[i] = 0; m_wrap[i] = 0;
            end
        end else if (ena) begin
            bit stp;
            hist = {hist[3:0], tick_in};
            if (nsamp < 5) nsamp++;
            stp = nsamp >= 5 && hist[3] && !hist[4];
            for (int i = 0; i < 2; i++) begin
                if (clr) begin
                    m_cnt[i] = 0; m_lap[i] = 0; m_run[i] = 0; m_hold[i] = 0; m_wrap[i] = 0;
                end else begin
                    if (lap_p) begin
                        if (m_hold[i]) m_hold[i] = 0;
                        else if (m_run[i]) begin
                            m_lap[i] = m_cnt[i];
                            m_hold[i] = 1;
                        end
                    end
                    m_wrap[i] = 0;
                    if (stp && m_run[i]) begin
                        m_cnt[i] = (m_cnt[i] + 1) % tot[i];
                        m_wrap[i] = (m_cnt[i] == 0);
                    end
                    m_run[i] = m_run[i] ^ ss;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk_in);
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                logic [24:0] g, e;
                g = (i == 0) ? {d0, running0, lap_hold0, wrap0} : {dw, runningw, lap_holdw, wrapw};
                e = ev(i);
                n_cmp++;
                if (g !== e) begin
                    n_bad++;
                    $display("FAIL model_cmp[%0d] @%0t: got %h expected %h", i, $time, g, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
        ss = 0;
        lap_p = 0;
        clr = 0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            tick_in = 1; cyc();
            tick_in = 0; cyc();
        end
    endtask

    task automatic pre_step();
        tick_in = 1; cyc();
        tick_in = 0; cyc();
        cyc();
    endtask

    initial begin
        idle(2);
        res = 0;
        chk("reset_disp", d0, mk(0, 0, 0));
        chk("reset_flags", {running0, lap_hold0, wrap0}, 3'b000);

        ss = 1; cyc();
        tick(100); idle(4);
        chk("one_second", d0, mk(0, 1, 0));
        chk("one_second_flags", {running0, wrap0}, 2'b10);

        tick_in = 1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("latency_pre", d0, mk(0, 1, 0));
        end
        cyc();
        chk("latency_edge3", d0, mk(0, 1, 1));
        idle(5);
        chk("single_step", d0, mk(0, 1, 1));
        tick_in = 0; idle(1);

        tick(1133); idle(4);
        chk("at_12_34", d0, mk(0, 12, 34));
        lap_p = 1; cyc();
        chk("lap_hold_set", lap_hold0, 1'b1);
        tick(50); idle(4);
        chk("lap_frozen", d0, mk(0, 12, 34));
        lap_p = 1; cyc();
        chk("lap_release", {d0, lap_hold0}, {mk(0, 12, 84), 1'b0});

        clr = 1; cyc();
        ss = 1; cyc();
        tick(500); idle(4);
        chk("at_5_00", d0, mk(0, 5, 0));
        lap_p = 1; cyc();
        pre_step();
        clr = 1; ss = 1; cyc();
        chk("clear_prio", {d0, running0, lap_hold0}, {mk(0, 0, 0), 2'b00});
        idle(4);
        chk("clear_step_lost", d0, mk(0, 0, 0));

        ss = 1; cyc();
        tick(7); idle(4);
        chk("at_0_07", d0, mk(0, 0, 7));
        pre_step();
        ss = 1; cyc();
        chk("ss_step", {d0, running0}, {mk(0, 0, 8), 1'b0});
        tick(10); idle(4);
        chk("stopped_ignores", d0, mk(0, 0, 8));
        lap_p = 1; cyc();
        chk("lap_stopped", lap_hold0, 1'b0);

        clr = 1; cyc();
        ss = 1; cyc();
        tick(11999); idle(4);
        chk("w_at_max", dw, mk(1, 59, 99));
        pre_step(); cyc();
        chk("w_wrapped", {dw, runningw, wrapw}, {mk(0, 0, 0), 2'b11});
        chk("d0_minute_carry", {d0, wrap0}, {mk(2, 0, 0), 1'b0});
        cyc();
        chk("w_wrap_pulse", wrapw, 1'b0);

        tick_in = 1; res = 1; cyc();
        res = 0; ss = 1; cyc();
        idle(8);
        chk("reset_high_tick", {d0, running0}, {mk(0, 0, 0), 1'b1});
        tick_in = 0; idle(2);
        tick(1); idle(4);
        chk("after_reset_tick", d0, mk(0, 0, 1));

        ena = 0; tick(5); ena = 1; idle(4);
        chk("ena_hold", d0, mk(0, 0, 1));

        for (int n = 0; n < 3000; n++) begin
            res = ($urandom_range(499) == 0);
            ena = ($urandom_range(7) != 0);
            if ($urandom_range(2) == 0) tick_in = ~tick_in;
            ss = ($urandom_range(19) == 0);
            lap_p = ($urandom_range(14) == 0);
            clr = ($urandom_range(199) == 0);
            @(posedge clk_in); #1;
        end
        res = 0; ena = 1; ss = 0; lap_p = 0; clr = 0;
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
